// File: rtl/freq_ring_multi_if.sv
// Interface bundling the host-side write path, the per-lane read ports and
// the random-read readback port of the frequency-selector ring.
interface freq_ring_multi_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 18,
    parameter int ADDR_W = 7
);
    logic                     clear;
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_data;
    logic [N_CH-1:0]          rd_en;
    logic [N_CH*DATA_W-1:0]   dout;
    logic [N_CH-1:0]          dout_valid;
    logic [N_CH*ADDR_W-1:0]   index;
    logic [ADDR_W:0]          count;
    logic                     ready;
    logic                     full;
    logic                     overflow;
    logic                     rand_rd_en;
    logic [ADDR_W-1:0]        rand_rd_addr;
    logic                     rand_rd_busy;
    logic                     rand_rd_valid;
    logic [DATA_W-1:0]        rand_rd_data;
    logic                     rand_rd_err;

    modport master (
        output clear, wr_en, wr_data, rd_en, rand_rd_en, rand_rd_addr,
        input  dout, dout_valid, index, count, ready, full, overflow,
               rand_rd_busy, rand_rd_valid, rand_rd_data, rand_rd_err
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en, rand_rd_en, rand_rd_addr,
        output dout, dout_valid, index, count, ready, full, overflow,
               rand_rd_busy, rand_rd_valid, rand_rd_data, rand_rd_err
    );
endinterface

// File: rtl/freq_ring_multi.sv
// Multi-lane ring buffer of frequency-selector entries. The host appends
// entries; each lane walks the loaded entries with its own wrapping pointer.
// A three-cycle random-read port provides readback of any loaded entry.
module freq_ring_multi #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 18,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic               dev_clk,
    input  logic               dev_rst,
    freq_ring_multi_if.slave   bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RR_IDLE  = 2'd0,
        RR_READ  = 2'd1,
        RR_VALID = 2'd2
    } rr_state_e;

    // Storage is sized to the full pointer range so any pointer value indexes it.
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              wr_ok_s;

    logic [DATA_W-1:0] dout_q  [N_CH];
    logic [DATA_W-1:0] dout_d  [N_CH];
    logic [ADDR_W-1:0] index_q [N_CH];
    logic [ADDR_W-1:0] index_d [N_CH];
    logic [CNT_W-1:0]  idx_inc_s [N_CH];
    logic [N_CH-1:0]   valid_q, valid_d;

    rr_state_e         state_q, state_d;
    logic              rr_accept_s;
    logic [ADDR_W-1:0] rr_addr_q, rr_addr_d;
    logic              rr_busy_q, rr_busy_d;
    logic              rr_valid_q, rr_valid_d;
    logic              rr_err_q, rr_err_d;
    logic [DATA_W-1:0] rr_data_q, rr_data_d;

    // Fill level, flags and sticky overflow; clear wins over a same-cycle write.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_ok_s    = 1'b0;
        if (bus.clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.wr_en) begin
            if (full_q) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
                wr_ok_s = 1'b1;
            end
        end else begin
            count_d = count_q;
        end
        ready_d = (count_d != '0);
        full_d  = (count_d == DEPTH_C);
    end

    // Per-lane pointer walk; the wrap test uses the registered count so an
    // entry appended this cycle is only reachable from the next cycle.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dout_d[i]    = dout_q[i];
            index_d[i]   = index_q[i];
            valid_d[i]   = 1'b0;
            idx_inc_s[i] = {1'b0, index_q[i]} + CNT_W'(1);
            if (bus.clear) begin
                dout_d[i]  = '0;
                index_d[i] = '0;
            end else if (bus.rd_en[i] && ready_q) begin
                dout_d[i]  = mem_q[index_q[i]];
                valid_d[i] = 1'b1;
                if (idx_inc_s[i] == count_q) begin
                    index_d[i] = '0;
                end else begin
                    index_d[i] = idx_inc_s[i][ADDR_W-1:0];
                end
            end else begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Random-read sequencer: accept -> memory read -> result pulse -> idle.
    always_comb begin
        state_d     = state_q;
        rr_accept_s = 1'b0;
        case (state_q)
            RR_IDLE: begin
                if (bus.rand_rd_en) begin
                    rr_accept_s = 1'b1;
                    state_d     = RR_READ;
                end else begin
                    state_d = RR_IDLE;
                end
            end
            RR_READ:  state_d = RR_VALID;
            RR_VALID: state_d = RR_IDLE;
            default:  state_d = RR_IDLE;
        endcase
        rr_busy_d  = (state_d != RR_IDLE);
        rr_valid_d = (state_q == RR_READ);
    end

    // Random-read address/error latch and result data; a clear while a read is
    // in flight turns the result into an error so stale data never leaks out.
    always_comb begin
        rr_addr_d = rr_addr_q;
        rr_err_d  = rr_err_q;
        rr_data_d = rr_data_q;
        if (rr_accept_s) begin
            rr_addr_d = bus.rand_rd_addr;
            rr_err_d  = ({1'b0, bus.rand_rd_addr} >= count_q);
        end else begin
            rr_addr_d = rr_addr_q;
        end
        if (bus.clear && (rr_accept_s || (state_q != RR_IDLE))) begin
            rr_err_d = 1'b1;
        end else begin
            rr_err_d = rr_err_d;
        end
        if (state_q == RR_READ) begin
            rr_data_d = rr_err_d ? '0 : mem_q[rr_addr_q];
        end else begin
            rr_data_d = rr_data_q;
        end
    end

    // Entry storage: contents need no reset, only appends are written.
    always_ff @(posedge dev_clk) begin
        if (wr_ok_s) begin
            mem_q[count_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    // State registers for fill level, lanes and the random-read port.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) begin
            count_q    <= '0;
            ready_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dout_q[i]  <= '0;
                index_q[i] <= '0;
            end
            state_q    <= RR_IDLE;
            rr_addr_q  <= '0;
            rr_busy_q  <= 1'b0;
            rr_valid_q <= 1'b0;
            rr_err_q   <= 1'b0;
            rr_data_q  <= '0;
        end else begin
            count_q    <= count_d;
            ready_q    <= ready_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            for (int i = 0; i < N_CH; i++) begin
                dout_q[i]  <= dout_d[i];
                index_q[i] <= index_d[i];
            end
            state_q    <= state_d;
            rr_addr_q  <= rr_addr_d;
            rr_busy_q  <= rr_busy_d;
            rr_valid_q <= rr_valid_d;
            rr_err_q   <= rr_err_d;
            rr_data_q  <= rr_data_d;
        end
    end

    // Pack lane registers onto the flat output buses.
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        assign bus.dout[g*DATA_W +: DATA_W]  = dout_q[g];
        assign bus.index[g*ADDR_W +: ADDR_W] = index_q[g];
    end

    assign bus.dout_valid    = valid_q;
    assign bus.count         = count_q;
    assign bus.ready         = ready_q;
    assign bus.full          = full_q;
    assign bus.overflow      = overflow_q;
    assign bus.rand_rd_busy  = rr_busy_q;
    assign bus.rand_rd_valid = rr_valid_q;
    assign bus.rand_rd_data  = rr_data_q;
    assign bus.rand_rd_err   = rr_err_q;
endmodule

// File: tb/tb_freq_ring_multi.sv
// Directed testbench for freq_ring_multi (N_CH=2, DATA_W=18, DEPTH=128).
module tb_freq_ring_multi;
    localparam int N_CH   = 2;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic dev_clk = 1'b0;
    logic dev_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    freq_ring_multi_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    freq_ring_multi #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .dev_clk (dev_clk),
        .dev_rst (dev_rst),
        .bus     (bus)
    );

    always #5 dev_clk = ~dev_clk;

    task automatic tick();
        @(posedge dev_clk);
        #1;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic load(input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        dev_rst = 1'b1;
        repeat (2) tick();
        flags = {bus.ready, bus.full, bus.overflow, bus.rand_rd_busy,
                 bus.rand_rd_valid, bus.rand_rd_err, |bus.dout_valid};
        checks++;
        if (flags !== 7'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0", flags); end
        checks++;
        if (bus.count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if ({bus.dout, bus.index, bus.rand_rd_data} !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected 0", bus.dout, bus.index, bus.rand_rd_data);
        end
        dev_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] ed [4];
        logic [ADDR_W-1:0] ei [4];
        ed = '{18'h0000A, 18'h0000B, 18'h0000C, 18'h0000A};
        ei = '{7'd1, 7'd2, 7'd0, 7'd1};
        load(18'h0000A); load(18'h0000B); load(18'h0000C);
        checks++;
        if (bus.count !== 8'd3 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL basic_count: got %0d/%b expected 3/1", bus.count, bus.ready);
        end
        bus.rd_en = 2'b01;
        checks++;
        if (bus.dout_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got 1 expected 0"); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.dout[17:0] !== ed[k] || bus.index[6:0] !== ei[k] || bus.dout_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL basic_read%0d: got dout=%h idx=%0d v=%b expected dout=%h idx=%0d v=1",
                         k, bus.dout[17:0], bus.index[6:0], bus.dout_valid[0], ed[k], ei[k]);
            end
        end
        bus.rd_en = 2'b00;
        tick();
        checks++;
        if (bus.dout_valid[0] !== 1'b0 || bus.dout[17:0] !== 18'h0000A) begin
            errors++; $display("FAIL basic_hold: got v=%b dout=%h expected v=0 dout=a", bus.dout_valid[0], bus.dout[17:0]);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        checks++;
        if (bus.count !== 8'd0) begin errors++; $display("FAIL ovf_clear: got %0d expected 0", bus.count); end
        for (int i = 0; i < DEPTH; i++) load(18'h00100 + 18'(i));
        checks++;
        if (bus.count !== 8'd128 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_fill: got cnt=%0d full=%b ovf=%b expected 128/1/0", bus.count, bus.full, bus.overflow);
        end
        load(18'h3FFFF);
        checks++;
        if (bus.count !== 8'd128 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_extra: got cnt=%0d full=%b ovf=%b expected 128/1/1", bus.count, bus.full, bus.overflow);
        end
        bus.rand_rd_en = 1'b1; bus.rand_rd_addr = 7'd127;
        tick();
        bus.rand_rd_en = 1'b0;
        tick();
        checks++;
        if (bus.rand_rd_valid !== 1'b1 || bus.rand_rd_data !== 18'h0017F || bus.rand_rd_err !== 1'b0) begin
            errors++; $display("FAIL ovf_last_entry: got v=%b d=%h e=%b expected 1/17f/0",
                               bus.rand_rd_valid, bus.rand_rd_data, bus.rand_rd_err);
        end
        tick();
        do_clear();
        checks++;
        if (bus.overflow !== 1'b0 || bus.full !== 1'b0) begin
            errors++; $display("FAIL ovf_clear_flags: got ovf=%b full=%b expected 0/0", bus.overflow, bus.full);
        end
    endtask

    task automatic test_lanes();
        logic [DATA_W-1:0] ent [3];
        logic [DATA_W-1:0] d1;
        int e0, e1;
        logic act1;
        ent = '{18'h00011, 18'h00022, 18'h00033};
        do_clear();
        load(ent[0]); load(ent[1]); load(ent[2]);
        e0 = 0; e1 = 0; d1 = '0;
        for (int c = 0; c < 6; c++) begin
            act1 = (c % 3 == 0);
            bus.rd_en = {act1, 1'b1};
            tick();
            checks++;
            if (bus.dout[17:0] !== ent[e0] || bus.index[6:0] !== 7'((e0 + 1) % 3)) begin
                errors++; $display("FAIL lanes_l0_c%0d: got %h/%0d expected %h/%0d",
                                   c, bus.dout[17:0], bus.index[6:0], ent[e0], (e0 + 1) % 3);
            end
            e0 = (e0 + 1) % 3;
            if (act1) begin d1 = ent[e1]; e1 = (e1 + 1) % 3; end
            checks++;
            if (bus.dout[35:18] !== d1 || bus.index[13:7] !== 7'(e1) || bus.dout_valid[1] !== act1) begin
                errors++; $display("FAIL lanes_l1_c%0d: got %h/%0d/%b expected %h/%0d/%b",
                                   c, bus.dout[35:18], bus.index[13:7], bus.dout_valid[1], d1, e1, act1);
            end
        end
        bus.rd_en = 2'b00;
    endtask

    task automatic test_wrap_write();
        logic [DATA_W-1:0] ed [5];
        logic [ADDR_W-1:0] ei [5];
        ed = '{18'h5, 18'h6, 18'h5, 18'h6, 18'h7};
        ei = '{7'd1, 7'd0, 7'd1, 7'd2, 7'd0};
        do_clear();
        load(18'h5); load(18'h6);
        bus.rd_en = 2'b01;
        for (int k = 0; k < 5; k++) begin
            bus.wr_en   = (k == 1);
            bus.wr_data = 18'h7;
            tick();
            checks++;
            if (bus.dout[17:0] !== ed[k] || bus.index[6:0] !== ei[k]) begin
                errors++; $display("FAIL wrap_step%0d: got %h/%0d expected %h/%0d",
                                   k, bus.dout[17:0], bus.index[6:0], ed[k], ei[k]);
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 2'b00;
        checks++;
        if (bus.count !== 8'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", bus.count); end
    endtask

    task automatic test_rand();
        logic [ADDR_W-1:0] ta [2];
        logic [DATA_W-1:0] td [2];
        logic              te [2];
        ta = '{7'd2, 7'd5};
        td = '{18'h7, 18'h0};
        te = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            bus.rand_rd_en = 1'b1; bus.rand_rd_addr = ta[k];
            tick();
            bus.rand_rd_en = 1'b0;
            checks++;
            if (bus.rand_rd_busy !== 1'b1 || bus.rand_rd_valid !== 1'b0) begin
                errors++; $display("FAIL rand%0d_p1: got busy=%b v=%b expected 1/0", k, bus.rand_rd_busy, bus.rand_rd_valid);
            end
            tick();
            checks++;
            if (bus.rand_rd_valid !== 1'b1 || bus.rand_rd_data !== td[k] || bus.rand_rd_err !== te[k]) begin
                errors++; $display("FAIL rand%0d_p2: got v=%b d=%h e=%b expected 1/%h/%b",
                                   k, bus.rand_rd_valid, bus.rand_rd_data, bus.rand_rd_err, td[k], te[k]);
            end
            tick();
            checks++;
            if (bus.rand_rd_busy !== 1'b0 || bus.rand_rd_valid !== 1'b0) begin
                errors++; $display("FAIL rand%0d_p3: got busy=%b v=%b expected 0/0", k, bus.rand_rd_busy, bus.rand_rd_valid);
            end
        end
        bus.rand_rd_en = 1'b1; bus.rand_rd_addr = 7'd1;
        tick();
        bus.rand_rd_addr = 7'd0;
        tick();
        bus.rand_rd_en = 1'b0;
        checks++;
        if (bus.rand_rd_valid !== 1'b1 || bus.rand_rd_data !== 18'h6) begin
            errors++; $display("FAIL rand_busy_result: got v=%b d=%h expected 1/6", bus.rand_rd_valid, bus.rand_rd_data);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus.rand_rd_valid !== 1'b0 || bus.rand_rd_busy !== 1'b0) begin
                errors++; $display("FAIL rand_busy_ignored%0d: got v=%b busy=%b expected 0/0", k, bus.rand_rd_valid, bus.rand_rd_busy);
            end
        end
        bus.rand_rd_en = 1'b1; bus.rand_rd_addr = 7'd0;
        tick();
        bus.rand_rd_en = 1'b0;
        do_clear();
        checks++;
        if (bus.rand_rd_valid !== 1'b1 || bus.rand_rd_err !== 1'b1 || bus.rand_rd_data !== 18'h0) begin
            errors++; $display("FAIL rand_clear: got v=%b e=%b d=%h expected 1/1/0", bus.rand_rd_valid, bus.rand_rd_err, bus.rand_rd_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_clear();
        load(18'h5); load(18'h6);
        bus.rd_en = 2'b11;
        bus.rand_rd_en = 1'b1; bus.rand_rd_addr = 7'd0;
        tick();
        bus.rand_rd_en = 1'b0;
        #2;
        dev_rst = 1'b1;
        #1;
        checks++;
        if ({bus.dout, bus.index, bus.dout_valid, bus.count, bus.rand_rd_busy, bus.rand_rd_valid,
             bus.rand_rd_data, bus.rand_rd_err, bus.ready} !== '0) begin
            errors++; $display("FAIL midrst_outputs: got dout=%h idx=%h v=%b cnt=%0d busy=%b rv=%b expected all 0",
                               bus.dout, bus.index, bus.dout_valid, bus.count, bus.rand_rd_busy, bus.rand_rd_valid);
        end
        bus.rd_en = 2'b00;
        tick();
        dev_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.rand_rd_valid !== 1'b0 || bus.rand_rd_busy !== 1'b0 || bus.dout_valid !== 2'b00) begin
                errors++; $display("FAIL midrst_stale%0d: got rv=%b busy=%b dv=%b expected 0/0/00",
                                   k, bus.rand_rd_valid, bus.rand_rd_busy, bus.dout_valid);
            end
        end
        load(18'h9); load(18'hA);
        bus.rd_en = 2'b01;
        tick();
        checks++;
        if (bus.dout[17:0] !== 18'h9 || bus.index[6:0] !== 7'd1) begin
            errors++; $display("FAIL clr_pre: got %h/%0d expected 9/1", bus.dout[17:0], bus.index[6:0]);
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.rd_en = 2'b00;
        checks++;
        if (bus.dout[17:0] !== 18'h0 || bus.index[6:0] !== 7'd0 || bus.dout_valid[0] !== 1'b0 || bus.count !== 8'd0) begin
            errors++; $display("FAIL clr_rd: got dout=%h idx=%0d v=%b cnt=%0d expected 0/0/0/0",
                               bus.dout[17:0], bus.index[6:0], bus.dout_valid[0], bus.count);
        end
    endtask

    initial begin
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = '0;
        bus.rand_rd_en = 1'b0; bus.rand_rd_addr = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_lanes();
        test_wrap_write();
        test_rand();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
